// File: rtl/rr_arb8.sv
// rr_arb8 - eight-way round-robin arbiter with a hold-limit timeout.
//
// One requester owns the shared resource at a time. Ownership is chosen by
// scanning req upward from a rotating priority pointer. The pointer moves to
// the slot after the last owner, which keeps arbitration fair. A grant ends
// when the owner signals done, when it drops its request, or when it has held
// the grant for MAX_HOLD cycles. At least one idle cycle separates two grants.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles (1..255), default 8
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset
//   req      in   [7:0] request vector, bit k = requester k
//   done     in   owner releases the resource (looked at only while granted)
//   gnt      out  [7:0] one-hot grant, bit k set iff gnt_vld and gnt_idx == k
//   gnt_idx  out  [2:0] current owner; keeps its last value while idle
//   gnt_vld  out  a grant is active
//   timeout  out  one-cycle pulse after a grant was forced off by the hold limit
module rr_arb8 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_vld_q, gnt_vld_d;
  logic       timeout_q, timeout_d;

  // First set bit of r, scanning from p upward with wrap 7->0.
  // Bit 3 of the result flags that something was found.
  function automatic logic [3:0] pick_first(input logic [7:0] r, input logic [2:0] p);
    logic       found;
    logic [2:0] sel;
    logic [2:0] idx;
    found = 1'b0;
    sel   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return {found, sel};
  endfunction

  logic [3:0] pick;
  logic       rel_done, rel_drop, rel_lim, release_now;

  assign pick        = pick_first(req, ptr_q);
  assign rel_done    = done;
  assign rel_drop    = ~req[gnt_idx_q];
  assign rel_lim     = (hold_cnt_q == HOLD_LIM);
  assign release_now = rel_done | rel_drop | rel_lim;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    gnt_idx_d  = gnt_idx_q;
    gnt_vld_d  = gnt_vld_q;
    timeout_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick[3]) begin
          state_d    = GRANT;
          gnt_idx_d  = pick[2:0];
          gnt_vld_d  = 1'b1;
          hold_cnt_d = 8'd1;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d    = IDLE;
          gnt_vld_d  = 1'b0;
          ptr_d      = gnt_idx_q + 3'd1;
          hold_cnt_d = 8'd0;
          // A limit hit that coincides with done or a request drop is an
          // ordinary release, so the pulse is reserved for a pure timeout.
          timeout_d  = rel_lim & ~rel_done & ~rel_drop;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 3'd0;
      hold_cnt_q <= 8'd0;
      gnt_idx_q  <= 3'd0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_idx_q  <= gnt_idx_d;
      gnt_vld_q  <= gnt_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  // Decoded only from registered state, so there is no path from req to gnt.
  assign gnt     = gnt_vld_q ? (8'b1 << gnt_idx_q) : 8'h00;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arb8.sv
module tb_rr_arb8;

  localparam int MH = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .gnt_vld(gnt_vld),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner (-1 when nobody holds the resource), how long it
  // has held it, the requester with top priority, and the pending timeout.
  int m_owner = -1;
  int m_last  = 0;
  int m_ten   = 0;
  int m_prio  = 0;
  bit m_to    = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_last = 0; m_ten = 0; m_prio = 0; m_to = 0;
    end else if (m_owner < 0) begin
      m_to = 0;
      for (int k = 0; k < 8; k++) begin
        if (m_owner < 0 && req[(m_prio + k) % 8]) begin
          m_owner = (m_prio + k) % 8;
          m_last  = m_owner;
          m_ten   = 1;
        end
      end
    end else begin
      bit by_done, by_drop, by_lim;
      by_done = done;
      by_drop = !req[m_owner];
      by_lim  = (m_ten == MH);
      if (by_done || by_drop || by_lim) begin
        m_to    = by_lim && !by_done && !by_drop;
        m_prio  = (m_owner + 1) % 8;
        m_owner = -1;
        m_ten   = 0;
      end else begin
        m_ten = m_ten + 1;
        m_to  = 0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e_gnt;
    e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    chk("model_gnt", gnt, e_gnt);
    chk("model_idx", {5'd0, gnt_idx}, 8'(m_last));
    chk("model_vld", {7'd0, gnt_vld}, {7'd0, (m_owner >= 0)});
    chk("model_timeout", {7'd0, timeout}, {7'd0, m_to});
  end

  task automatic wait_grant(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_vld === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({nm, "_wait_grant"}, 8'h00, 8'h01);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    @(negedge clk);
    chk("reset_gnt", gnt, 8'h00);
    chk("reset_vld", {7'd0, gnt_vld}, 8'h00);
    rst = 1'b0;
  endtask

  logic [7:0] rot_tbl [9];
  int         fair_tbl [4];

  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    rot_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    fair_tbl = '{0, 7, 0, 7};

    // Reset, then a single request from requester 2
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 8'h00);
      chk("rst_idx", {5'd0, gnt_idx}, 8'h00);
      chk("rst_vld", {7'd0, gnt_vld}, 8'h00);
      chk("rst_timeout", {7'd0, timeout}, 8'h00);
    end
    rst = 1'b0; req = 8'h04;
    wait_grant("single");
    chk("single_gnt", gnt, 8'h04);
    chk("single_idx", {5'd0, gnt_idx}, 8'd2);
    @(negedge clk);
    chk("single_gnt_c2", gnt, 8'h04);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    chk("single_released", gnt, 8'h00);
    chk("single_timeout", {7'd0, timeout}, 8'h00);
    done = 1'b0; req = 8'h00;

    // Full rotation with wrap
    do_reset();
    req = 8'hFF;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("rot_vld", {7'd0, gnt_vld}, 8'h01);
      chk("rot_gnt", gnt, rot_tbl[j]);
      chk("rot_idx", {5'd0, gnt_idx}, 8'(j % 8));
      done = 1'b1;
      @(negedge clk);
      chk("rot_gap", gnt, 8'h00);
      done = 1'b0;
    end

    // Fairness between requesters 0 and 7
    do_reset();
    req = 8'h81;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("fair_idx", {5'd0, gnt_idx}, 8'(fair_tbl[j]));
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
    end

    // Hold-limit timeout on requester 4
    do_reset();
    req = 8'h10;
    wait_grant("hold");
    begin
      int n;
      n = 0;
      while (gnt === 8'h10 && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("hold_tenure", 8'(n), 8'(MH));
    end
    chk("hold_timeout", {7'd0, timeout}, 8'h01);
    chk("hold_gap", gnt, 8'h00);
    @(negedge clk);
    chk("hold_regrant", gnt, 8'h10);
    chk("hold_timeout_clr", {7'd0, timeout}, 8'h00);

    // done together with the hold limit is a normal release
    repeat (3) @(negedge clk);
    chk("simul_c4", gnt, 8'h10);
    done = 1'b1;
    @(negedge clk);
    chk("simul_done_gnt", gnt, 8'h00);
    chk("simul_done_timeout", {7'd0, timeout}, 8'h00);
    done = 1'b0;

    // Request drop in grant cycle 2
    wait_grant("drop");
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    chk("drop_gnt", gnt, 8'h00);
    chk("drop_timeout", {7'd0, timeout}, 8'h00);

    // Reset while requester 5 holds the grant
    do_reset();
    req = 8'hFF;
    begin
      bit found;
      found = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (gnt_vld === 1'b1 && gnt_idx === 3'd5) begin
          found = 1;
          break;
        end
        done = gnt_vld;
      end
      chk("mid_found5", {7'd0, found}, 8'h01);
    end
    rst = 1'b1; done = 1'b0;
    @(negedge clk);
    chk("mid_rst_gnt", gnt, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_first_idx", {5'd0, gnt_idx}, 8'h00);
    chk("mid_first_gnt", gnt, 8'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : req | 8'($urandom & 32'h11);
      done = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 63) == 0);
    end
    rst = 1'b0; req = 8'h00; done = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
